// File: rtl/burst_cmd_serializer.sv
// Host-side serializer for the burst control command interface.
// Captures one parallel command, then drives a fixed frame: one ARM cycle,
// ADDR_W serial cycles (address and burst length, LSB first), a HOLD phase
// that waits for xfer_done or times out, and a GAP with burst_en low.
module burst_cmd_serializer #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_mode_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic              xfer_done_i,
    output logic              burst_en_o,
    output logic              mode_sel_o,
    output logic              burst_len_in_o,
    output logic              addr_in_o,
    output logic              busy_o,
    output logic              timeout_err_o
);

    localparam int unsigned BIT_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int unsigned HOLD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(ADDR_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [ADDR_W-1:0]   addr_sh_q;
    logic [ADDR_W-1:0]   len_sh_q;

    logic                cmd_ready_q;
    logic                burst_en_q;
    logic                mode_sel_q;
    logic                len_in_q;
    logic                addr_in_q;
    logic                busy_q;
    logic                timeout_err_q;

    // Frame sequencer; every output register holds the value for the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            addr_sh_q     <= '0;
            len_sh_q      <= '0;
            cmd_ready_q   <= 1'b0;
            burst_en_q    <= 1'b0;
            mode_sel_q    <= 1'b0;
            len_in_q      <= 1'b0;
            addr_in_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        state_q     <= ST_ARM;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        burst_en_q  <= 1'b1;
                        mode_sel_q  <= cmd_mode_i;
                        addr_sh_q   <= cmd_addr_i;
                        // Single transfers carry no length; zero it once at capture.
                        len_sh_q    <= cmd_mode_i ? ADDR_W'(cmd_len_i) : '0;
                        len_in_q    <= 1'b0;
                        addr_in_q   <= 1'b0;
                        bit_cnt_q   <= '0;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ARM: begin
                    state_q   <= ST_SHIFT;
                    bit_cnt_q <= '0;
                    addr_in_q <= addr_sh_q[0];
                    len_in_q  <= len_sh_q[0];
                    addr_sh_q <= addr_sh_q >> 1;
                    len_sh_q  <= len_sh_q >> 1;
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q    <= ST_HOLD;
                        addr_in_q  <= 1'b0;
                        len_in_q   <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        addr_in_q <= addr_sh_q[0];
                        len_in_q  <= len_sh_q[0];
                        addr_sh_q <= addr_sh_q >> 1;
                        len_sh_q  <= len_sh_q >> 1;
                    end
                end
                ST_HOLD: begin
                    // Completion wins over a coincident timeout.
                    if (xfer_done_i || (hold_cnt_q == HOLD_LAST)) begin
                        state_q       <= ST_GAP;
                        burst_en_q    <= 1'b0;
                        mode_sel_q    <= 1'b0;
                        gap_cnt_q     <= '0;
                        timeout_err_q <= ~xfer_done_i;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    burst_en_q  <= 1'b0;
                    mode_sel_q  <= 1'b0;
                    len_in_q    <= 1'b0;
                    addr_in_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign burst_en_o     = burst_en_q;
    assign mode_sel_o     = mode_sel_q;
    assign burst_len_in_o = len_in_q;
    assign addr_in_o      = addr_in_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_burst_cmd_serializer.sv
// Bench for burst_cmd_serializer: a frame-level model builds the expected
// per-cycle output trace from the command; each scenario compares it inline.
module tb_burst_cmd_serializer;

    localparam int unsigned AW  = 20;
    localparam int unsigned LW  = 8;
    localparam int unsigned TO  = 16;
    localparam int unsigned GAP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] cmd_addr;
    logic          xfer_done;
    logic          burst_en;
    logic          mode_sel;
    logic          burst_len_in;
    logic          addr_in;
    logic          busy;
    logic          timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observed vector: {cmd_ready, burst_en, mode_sel, burst_len_in, addr_in, busy, timeout_err}
    wire [6:0] obs_w = {cmd_ready, burst_en, mode_sel, burst_len_in, addr_in, busy, timeout_err};

    localparam logic [6:0] V_RESET = 7'b000_0000;
    localparam logic [6:0] V_IDLE  = 7'b100_0000;

    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    bit         done_q[$];

    always #5 clk = ~clk;

    burst_cmd_serializer #(
        .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_mode_i     (cmd_mode),
        .cmd_len_i      (cmd_len),
        .cmd_addr_i     (cmd_addr),
        .xfer_done_i    (xfer_done),
        .burst_en_o     (burst_en),
        .mode_sel_o     (mode_sel),
        .burst_len_in_o (burst_len_in),
        .addr_in_o      (addr_in),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err)
    );

    // Expected trace of one frame, starting with the idle cycle in which the command is offered.
    // done_at: HOLD cycle index carrying xfer_done, or outside 0..TO-1 for none.
    function automatic void model_frame(input logic mode, input logic [LW-1:0] len,
                                        input logic [AW-1:0] addr, input int done_at,
                                        input bit stray_done);
        bit timed_out;
        int hold_cycles;
        logic lb, ab;
        exp_q.delete();
        done_q.delete();
        exp_q.push_back(V_IDLE);                    done_q.push_back(1'b0);
        exp_q.push_back({3'b010 | {2'b00, mode}, 4'b0010}); done_q.push_back(1'b0);
        for (int i = 0; i < int'(AW); i++) begin
            lb = (mode && i < int'(LW)) ? 1'((len >> i)) : 1'b0;
            ab = 1'((addr >> i));
            exp_q.push_back({1'b0, 1'b1, mode, lb, ab, 1'b1, 1'b0});
            done_q.push_back(stray_done && i == 5);
        end
        timed_out   = !(done_at >= 0 && done_at < int'(TO));
        hold_cycles = timed_out ? int'(TO) : done_at + 1;
        for (int k = 0; k < hold_cycles; k++) begin
            exp_q.push_back({1'b0, 1'b1, mode, 4'b0010});
            done_q.push_back(!timed_out && k == done_at);
        end
        for (int g = 0; g < int'(GAP); g++) begin
            exp_q.push_back({6'b000001, (g == 0) && timed_out});
            done_q.push_back(stray_done && g == 0);
        end
    endfunction

    // Drive one frame from the idle cycle on; inputs change on the falling edge.
    task automatic drive_frame(input logic mode, input logic [LW-1:0] len,
                               input logic [AW-1:0] addr, input bit hold_valid);
        obs_q.delete();
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            obs_q.push_back(obs_w);
            xfer_done = done_q[c];
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_mode  = mode;
                cmd_len   = len;
                cmd_addr  = addr;
            end else begin
                cmd_valid = hold_valid;
                cmd_mode  = 1'($urandom);
                cmd_len   = LW'($urandom);
                cmd_addr  = AW'($urandom);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; xfer_done = 1'b0;
        cmd_mode = 1'b0; cmd_len = '0; cmd_addr = '0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            total_cnt++;
            if (obs_w !== V_RESET) $display("FAIL reset_hold cycle %0d: observed %b expected %b", r, obs_w, V_RESET);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs_w !== V_IDLE) $display("FAIL reset_release: observed %b expected %b", obs_w, V_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_burst_pattern();
        model_frame(1'b1, 8'hA5, 20'h00001, 5, 1'b0);
        drive_frame(1'b1, 8'hA5, 20'h00001, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL burst_pattern cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_mode();
        model_frame(1'b0, 8'hFF, 20'hFFFFF, 2, 1'b0);
        drive_frame(1'b0, 8'hFF, 20'hFFFFF, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL single_mode cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_done_ignored();
        logic [LW-1:0] len = LW'($urandom);
        logic [AW-1:0] addr = AW'($urandom);
        model_frame(1'b1, len, addr, 5, 1'b1);
        drive_frame(1'b1, len, addr, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL done_ignored cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        logic [AW-1:0] addr = AW'($urandom);
        model_frame(1'b1, 8'h3C, addr, -1, 1'b0);
        drive_frame(1'b1, 8'h3C, addr, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL timeout cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_coincident_done();
        logic [AW-1:0] addr = AW'($urandom);
        model_frame(1'b1, 8'h81, addr, int'(TO) - 1, 1'b0);
        drive_frame(1'b1, 8'h81, addr, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL coincident_done cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_len_zero();
        logic [AW-1:0] addr = AW'($urandom);
        model_frame(1'b1, 8'h00, addr, 0, 1'b0);
        drive_frame(1'b1, 8'h00, addr, 1'b0);
        foreach (exp_q[c]) begin
            total_cnt++;
            if (obs_q[c] !== exp_q[c]) $display("FAIL len_zero cycle %0d: observed %b expected %b", c, obs_q[c], exp_q[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            logic          mode = 1'($urandom);
            logic [LW-1:0] len  = LW'($urandom);
            logic [AW-1:0] addr = AW'($urandom);
            int            dn   = int'($urandom_range(TO, 0)) - 1;
            model_frame(mode, len, addr, dn, 1'b1);
            drive_frame(mode, len, addr, 1'b1);
            foreach (exp_q[c]) begin
                total_cnt++;
                if (obs_q[c] !== exp_q[c]) $display("FAIL back_to_back frame %0d cycle %0d: observed %b expected %b", f, c, obs_q[c], exp_q[c]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            logic          mode = 1'($urandom);
            logic [LW-1:0] len  = LW'($urandom);
            logic [AW-1:0] addr = AW'($urandom);
            int            dn   = int'($urandom_range(TO + 1, 0)) - 1;
            bit            sd   = 1'($urandom);
            model_frame(mode, len, addr, dn, sd);
            drive_frame(mode, len, addr, 1'b0);
            foreach (exp_q[c]) begin
                total_cnt++;
                if (obs_q[c] !== exp_q[c]) $display("FAIL random frame %0d cycle %0d: observed %b expected %b", f, c, obs_q[c], exp_q[c]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        model_frame(1'b1, 8'h5A, 20'hABCDE, -1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total_cnt++;
            if (obs_w !== exp_q[c]) $display("FAIL pre_reset cycle %0d: observed %b expected %b", c, obs_w, exp_q[c]);
            else pass_cnt++;
            cmd_valid = (c == 0);
            cmd_mode  = 1'b1;
            cmd_len   = 8'h5A;
            cmd_addr  = 20'hABCDE;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            total_cnt++;
            if (obs_w !== V_RESET) $display("FAIL mid_shift_reset cycle %0d: observed %b expected %b", r, obs_w, V_RESET);
            else pass_cnt++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs_w !== V_IDLE) $display("FAIL post_reset_idle cycle %0d: observed %b expected %b", k, obs_w, V_IDLE);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_burst_pattern();
        test_single_mode();
        test_done_ignored();
        test_timeout();
        test_coincident_done();
        test_len_zero();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        test_burst_pattern();
        xfer_done = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
